bus_fabric: RTL

Parametrised single-master, N-slave bus fabric between the processor and its memory/peripheral slaves. Decodes the processor address against per-slave base/mask pairs and registers the request. Drives the selected slave until it acknowledges, and returns read data with a ready/error response. Adds wait-state support, unmapped-address errors and a slave timeout.

---
 rtl/bus_fabric.sv | 136 +++++++++++++
 1 files changed

// File: rtl/bus_fabric.sv
// Single-master, N-slave bus fabric: address decode, registered slave access with
// wait states, unmapped/conflict error responses and a per-access slave timeout.
module bus_fabric #(
  parameter int unsigned                    N_SLAVES   = 2,
  parameter int unsigned                    ADDR_W     = 32,
  parameter int unsigned                    DATA_W     = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0]     SLAVE_BASE = {32'h80000000, 32'h00000000},
  parameter logic [N_SLAVES*ADDR_W-1:0]     SLAVE_MASK = {32'hFFFFFFF0, 32'h80000000},
  parameter int unsigned                    TIMEOUT    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         proc_rd_en_i,
  input  logic                         proc_wr_en_i,
  input  logic [ADDR_W-1:0]            proc_addr_i,
  input  logic [DATA_W-1:0]            proc_data_i,
  output logic [DATA_W-1:0]            proc_data_o,
  output logic                         proc_ready_o,
  output logic                         proc_err_o,
  output logic                         busy_o,
  output logic [N_SLAVES-1:0]          slv_rd_en_o,
  output logic [N_SLAVES-1:0]          slv_wr_en_o,
  output logic [ADDR_W-1:0]            slv_addr_o,
  output logic [DATA_W-1:0]            slv_data_o,
  input  logic [N_SLAVES*DATA_W-1:0]   slv_data_i,
  input  logic [N_SLAVES-1:0]          slv_ready_i
);

  localparam int unsigned SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state;
  logic [SEL_W-1:0]    sel;
  logic                is_rd;
  logic [CNT_W-1:0]    wait_cnt;

  logic                hit;
  logic [SEL_W-1:0]    hit_idx;
  logic [N_SLAVES-1:0] hit_onehot;
  logic                sel_ready;
  logic [DATA_W-1:0]   sel_data;

  // Address decode; scanning downward lets the lowest matching index win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((proc_addr_i & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  assign hit_onehot = N_SLAVES'(1) << hit_idx;
  assign sel_ready  = slv_ready_i[sel];
  assign sel_data   = slv_data_i[sel*DATA_W +: DATA_W];

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sel          <= '0;
      is_rd        <= 1'b0;
      wait_cnt     <= '0;
      proc_data_o  <= '0;
      proc_ready_o <= 1'b0;
      proc_err_o   <= 1'b0;
      busy_o       <= 1'b0;
      slv_rd_en_o  <= '0;
      slv_wr_en_o  <= '0;
      slv_addr_o   <= '0;
      slv_data_o   <= '0;
    end else begin
      proc_ready_o <= 1'b0;
      proc_err_o   <= 1'b0;
      proc_data_o  <= '0;
      case (state)
        IDLE: begin
          if (proc_rd_en_i && proc_wr_en_i) begin
            state        <= RESP;
            busy_o       <= 1'b1;
            proc_ready_o <= 1'b1;
            proc_err_o   <= 1'b1;
          end else if (proc_rd_en_i || proc_wr_en_i) begin
            if (hit) begin
              state       <= ACCESS;
              busy_o      <= 1'b1;
              sel         <= hit_idx;
              is_rd       <= proc_rd_en_i;
              wait_cnt    <= '0;
              slv_addr_o  <= proc_addr_i;
              slv_data_o  <= proc_data_i;
              slv_rd_en_o <= proc_rd_en_i ? hit_onehot : '0;
              slv_wr_en_o <= proc_rd_en_i ? '0 : hit_onehot;
            end else begin
              state        <= RESP;
              busy_o       <= 1'b1;
              proc_ready_o <= 1'b1;
              proc_err_o   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          // Ready is checked first so a last-cycle acknowledge beats the timeout.
          if (sel_ready) begin
            state        <= RESP;
            slv_rd_en_o  <= '0;
            slv_wr_en_o  <= '0;
            proc_ready_o <= 1'b1;
            proc_data_o  <= is_rd ? sel_data : '0;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            state        <= RESP;
            slv_rd_en_o  <= '0;
            slv_wr_en_o  <= '0;
            proc_ready_o <= 1'b1;
            proc_err_o   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
